// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter/sequencer sharing one register-bus slave port among
// NUM_REQ requesters. One transaction in flight; one strobe per transaction;
// read data captured one cycle after the strobe and returned to the requester.
module reg_bus_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int CNT_W   = 16
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [NUM_REQ-1:0]     i_req,
   input  logic [NUM_REQ-1:0]     i_req_write,
   input  logic [NUM_REQ*32-1:0]  i_req_addr,
   input  logic [NUM_REQ*32-1:0]  i_req_wdata,
   output logic [NUM_REQ-1:0]     o_req_ack,
   output logic [NUM_REQ-1:0]     o_rsp_valid,
   output logic [31:0]            o_rsp_rdata,
   output logic                   o_write,
   output logic                   o_read,
   output logic [31:0]            o_addr,
   output logic [31:0]            o_wdata,
   input  logic [31:0]            i_rdata,
   output logic                   o_busy,
   output logic [CNT_W-1:0]       o_txn_cnt
);

   localparam int PTR_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {IDLE, CMD, RDATA, RESP} state_t;

   state_t           state, state_nxt;
   logic [PTR_W-1:0] rr_ptr;    // first requester considered at the next grant
   logic [PTR_W-1:0] gnt;       // requester owning the in-flight transaction
   logic             op_write;  // latched op of the in-flight transaction
   logic [PTR_W-1:0] pick;
   logic             found;

   // Round-robin search: first set request at or above rr_ptr, wrapping to 0
   always_comb begin
      pick  = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && i_req[(int'(rr_ptr) + i) % NUM_REQ]) begin
            found = 1'b1;
            pick  = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
         end
      end
   end

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state: reads take an extra cycle to wait for registered read data
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (found) state_nxt = CMD;
         CMD:     state_nxt = op_write ? RESP : RDATA;
         RDATA:   state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Transaction latch, read-data capture and completion counter
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rr_ptr      <= '0;
         gnt         <= '0;
         op_write    <= 1'b0;
         o_addr      <= '0;
         o_wdata     <= '0;
         o_rsp_rdata <= '0;
         o_txn_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (found) begin
                  gnt      <= pick;
                  op_write <= i_req_write[pick];
                  o_addr   <= i_req_addr[int'(pick)*32 +: 32];
                  o_wdata  <= i_req_wdata[int'(pick)*32 +: 32];
                  rr_ptr   <= PTR_W'((int'(pick) + 1) % NUM_REQ);
               end
            end
            // Writes respond with zero data; clear it while the strobe is out
            CMD:     if (op_write) o_rsp_rdata <= '0;
            RDATA:   o_rsp_rdata <= i_rdata;
            RESP:    o_txn_cnt <= o_txn_cnt + 1'b1;
            default: ;
         endcase
      end
   end

   // Outputs decoded from registered state only; no path from i_req
   always_comb begin
      o_write     = (state == CMD) &&  op_write;
      o_read      = (state == CMD) && !op_write;
      o_req_ack   = (state == CMD)  ? (NUM_REQ'(1) << gnt) : '0;
      o_rsp_valid = (state == RESP) ? (NUM_REQ'(1) << gnt) : '0;
      o_busy      = (state != IDLE);
   end

endmodule

// File: doc/reg_bus_arbiter.md
# reg_bus_arbiter

Round-robin arbiter and sequencer that shares the single register-bus slave port (write/read strobes, 32-bit address, write data, registered read data with one-cycle latency) among NUM_REQ requesters. It sits between the requesters (CPU bridge, debug port, DMA config engine) and the register block. It serialises their accesses, issues exactly one strobe per transaction, captures the read data one cycle later, and returns it to the originating requester.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- CNT_W, 16, width of the completed-transaction counter

Ports:
- i_clk  in  1  clock. One clock domain; all logic on the rising edge.
- i_rst  in  1  reset. Synchronous and active-high.
- i_req  in  NUM_REQ  per-requester request. Must be held until o_req_ack.
- i_req_write  in  NUM_REQ  per-requester op: 1 = write, 0 = read.
- i_req_addr  in  NUM_REQ*32  per-requester address. Slice k is bits [32k+31:32k].
- i_req_wdata  in  NUM_REQ*32  per-requester write data. Same slicing.
- o_req_ack  out  NUM_REQ  one-hot, one-cycle pulse. Request accepted.
- o_rsp_valid  out  NUM_REQ  one-hot, one-cycle pulse. Transaction complete.
- o_rsp_rdata  out  32  read data. Valid with o_rsp_valid; 0 for writes.
- o_write  out  1  write strobe to register block.
- o_read  out  1  read strobe to register block.
- o_addr  out  32  address to register block.
- o_wdata  out  32  write data to register block.
- i_rdata  in  32  registered read data from register block.
- o_busy  out  1  high whenever the state is not IDLE.
- o_txn_cnt  out  CNT_W  completed transactions. Wraps at 2^CNT_W.

## Operation
- FSM states: IDLE, CMD, RDATA, RESP.
- **IDLE**
  - If any i_req bit is set, pick the grant g: the first set bit scanning upward from rr_ptr, wrapping past NUM_REQ-1 to 0.
  - Latch g, i_req_write[g], and the address and write-data slices for g.
  - Set rr_ptr = (g+1) mod NUM_REQ.
  - Go to CMD. With no request, stay in IDLE.
- **CMD**
  - Assert o_write or o_read for exactly this cycle, according to the latched op.
  - o_addr and o_wdata carry the latched values.
  - Pulse o_req_ack[g].
  - Next state is RDATA for a read, RESP for a write.
- **RDATA**
  - No strobe.
  - Capture i_rdata into the response register.
- **RESP**
  - Pulse o_rsp_valid[g].
  - o_rsp_rdata holds the captured data for a read, 32'h0 for a write.
  - Increment o_txn_cnt.
  - Return to IDLE.
- Changes to a requester's inputs after the IDLE latch cycle are ignored. This includes dropping i_req: the latched transaction still completes and responds.
- Only one transaction is in flight at a time; no pipelining.
- o_write and o_read are never high together and never high outside CMD.
- o_addr and o_wdata hold their latched value between transactions; they do not return to 0.
- rr_ptr only advances on a grant.

## Timing
- Reset values while i_rst is high at a clock edge:
  - State IDLE, rr_ptr 0.
  - o_req_ack, o_rsp_valid, o_write, o_read all 0.
  - o_addr, o_wdata, o_rsp_rdata all 0.
  - o_busy 0, o_txn_cnt 0.
- Cycle numbering: i_req is sampled in IDLE at cycle 0.
  - Cycle 1 (CMD): strobe and o_req_ack.
  - Read: cycle 2 RDATA (i_rdata valid), cycle 3 RESP. Four-cycle occupancy.
  - Write: cycle 2 RESP. Three-cycle occupancy.
  - Next grant is evaluated in IDLE at cycle 4 (read) or cycle 3 (write).
- All outputs are registered or decoded from registered state; there is no combinational path from i_req to any output.
- Simultaneous requests: exactly one is granted per IDLE cycle. The others wait and are re-evaluated in the next IDLE.
- Starvation bound: a held request is granted within NUM_REQ grants.
- Reset mid-transaction (any non-IDLE state):
  - The transaction is abandoned.
  - No o_rsp_valid is issued for it.
  - Outputs take their reset values on the following cycle.
- o_txn_cnt wraps from 2^CNT_W-1 to 0 with no sticky flag.

## Test plan
- **Reset:** hold i_rst 3 cycles with all i_req set -> all outputs 0, state IDLE, no ack.
- **Single write:** requester 2 writes addr 0x00, data 0xA5A5A5A5 -> o_write=1 and o_req_ack=4'b0100 in cycle 1; o_rsp_valid=4'b0100 with o_rsp_rdata=0 in cycle 2; o_txn_cnt=1.
- **Single read:** requester 0 reads addr 0x00; slave model returns 0x00000001 one cycle after o_read -> o_read high in cycle 1 only; o_rsp_valid=4'b0001 with o_rsp_rdata=0x00000001 in cycle 3.
- **Round-robin:** all four i_req held continuously as writes -> grant order 0,1,2,3,0,…; each ack is 3 cycles apart; never two acks in one cycle.
- **Drop after latch:** requester 1 asserts for one cycle only, then deasserts and changes its addr -> transaction completes with the originally latched address; o_rsp_valid[1] still pulses.
- **Reset mid-read and counter wrap:**
  - Assert i_rst in RDATA -> no o_rsp_valid; rr_ptr=0 afterwards.
  - Separately, with CNT_W=4, run 16 writes -> o_txn_cnt returns to 0.
